// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int ADDR_W_DEFAULT = 5;
  localparam int DATA_W_DEFAULT = 32;

  // Opcode field position within the instruction word.
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int OP_W  = OP_HI - OP_LO + 1;

  localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 5'b11111;

endpackage

// File: rtl/instr_fetch_seq_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: owns the PC, captures memory words into a one-entry
// output register, detects halt, accepts redirects and counts issues.
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int              ADDR_W  = ADDR_W_DEFAULT,
  parameter int              DATA_W  = DATA_W_DEFAULT,
  parameter logic [OP_W-1:0] HALT_OP = HALT_OP_DEFAULT,
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              vld_q, vld_d;
  logic              cnt_clr;
  logic              load;
  logic              is_halt;

  assign load    = !vld_q || instr_ready;
  assign is_halt = (imem_data[OP_HI:OP_LO] == HALT_OP);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    vld_d      = vld_q;
    cnt_clr    = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        // A redirect wins over everything, including a word being consumed.
        if (redirect_valid) begin
          vld_d = 1'b0;
          pc_d  = redirect_pc;
        end else if (load) begin
          if (is_halt) begin
            vld_d   = 1'b0;
            state_d = HALTED;
          end else begin
            instr_d    = imem_data;
            instr_pc_d = pc_q;
            vld_d      = 1'b1;
            pc_d       = pc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      vld_q      <= vld_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (reset),
    .clr (cnt_clr),
    .inc (vld_q && instr_ready),
    .cnt (issue_count)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == HALTED);
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Scoreboard bench for instr_fetch_seq; a second narrow-counter instance
// exercises issue_count saturation in a short run.
module tb_instr_fetch_seq;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, instr_ready, redirect_valid;
  logic [4:0]  redirect_pc, imem_addr, instr_pc;
  logic [31:0] imem_data, instr;
  logic        instr_valid, halted, busy;
  logic [15:0] issue_count;

  logic        reset2, start2, ready2;
  logic [4:0]  imem_addr2, instr_pc2;
  logic [31:0] imem_data2, instr2;
  logic        valid2, halted2, busy2;
  logic [3:0]  cnt2;

  logic [31:0] mem [32];
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = {27'h0, imem_addr2};

  always #5 clk = ~clk;

  instr_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(halted), .busy(busy),
    .issue_count(issue_count)
  );

  instr_fetch_seq #(.CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .instr_valid(valid2), .instr(instr2), .instr_pc(instr_pc2),
    .instr_ready(ready2), .redirect_valid(1'b0),
    .redirect_pc(5'd0), .halted(halted2), .busy(busy2),
    .issue_count(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_halt_prog();
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i * 17);
    mem[12] = 32'hF800_0000;
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: unexpected issue pc=%0d instr=%h, scoreboard empty", tag, instr_pc, instr);
    end else begin
      e = sb.pop_front();
      if (instr_pc !== e.pc || instr !== e.data) begin
        failures++;
        $display("FAIL %s: got pc=%0d instr=%h, expected pc=%0d instr=%h", tag, instr_pc, instr, e.pc, e.data);
      end
    end
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || imem_addr !== 5'd0 || issue_count !== 16'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL %s_start: busy=%b addr=%0d cnt=%0d vld=%b halted=%b, expected 1 0 0 0 0",
               tag, busy, imem_addr, issue_count, instr_valid, halted);
    end
  endtask

  // Runs the 13-word halt program; optional 3-cycle stall while word 4 is held.
  task automatic run_program(input bit stall_en, input string tag);
    int  stalls = 3;
    bit  exp_halt = 1'b0;
    bit  done = 1'b0;
    exp_t e;
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      e.pc = 5'(i); e.data = mem[i];
      sb.push_back(e);
    end
    pulse_start(tag);
    for (int c = 0; c < 100 && !done; c++) begin
      if (exp_halt) begin
        checks++;
        if (halted !== 1'b1) begin
          failures++;
          $display("FAIL %s_halt_timing: halted=%b, expected 1", tag, halted);
        end
        done = 1'b1;
      end else begin
        instr_ready = 1'b1;
        if (stall_en && instr_valid && instr_pc == 5'd4 && stalls > 0) begin
          instr_ready = 1'b0;
          stalls--;
          checks++;
          if (instr !== mem[4] || imem_addr !== 5'd5) begin
            failures++;
            $display("FAIL %s_stall: instr=%h addr=%0d, expected %h 5", tag, instr, imem_addr, mem[4]);
          end
        end
        if (instr_valid && instr_ready) pop_compare(tag);
        exp_halt = busy && imem_addr == 5'd12 && (!instr_valid || instr_ready);
        step();
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: halt not reached, halted=%b", tag, halted);
    end
    checks++;
    if (sb.size() != 0 || issue_count !== 16'd12 || instr_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: left=%0d cnt=%0d vld=%b busy=%b, expected 0 12 0 0",
               tag, sb.size(), issue_count, instr_valid, busy);
    end
    checks++;
    if (stall_en && stalls != 0) begin
      failures++;
      $display("FAIL %s_stall_seen: stalls left=%0d, expected 0", tag, stalls);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1;
    start = 1'b0; start2 = 1'b0; instr_ready = 1'b0; ready2 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 5'd0;
    load_halt_prog();
    step(); step();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 5'd0 || imem_addr !== 5'd0 ||
        issue_count !== 16'd0 || halted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: vld=%b instr=%h ipc=%0d addr=%0d cnt=%0d halted=%b busy=%b, expected all 0",
               instr_valid, instr, instr_pc, imem_addr, issue_count, halted, busy);
    end
    reset = 1'b0;
    // Redirect must be ignored while idle.
    redirect_valid = 1'b1; redirect_pc = 5'd7;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 5'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_redirect: addr=%0d busy=%b, expected 0 0", imem_addr, busy);
    end
  endtask

  task automatic test_run();
    run_program(1'b0, "run");
  endtask

  task automatic test_restart();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre: halted=%b, expected 1", halted);
    end
    run_program(1'b0, "restart");
  endtask

  task automatic test_backpressure();
    run_program(1'b1, "backpressure");
  endtask

  task automatic test_redirect();
    int ph = 0;
    exp_t e;
    sb.delete();
    e.pc = 5'd0;  e.data = mem[0];  sb.push_back(e);
    e.pc = 5'd1;  e.data = mem[1];  sb.push_back(e);
    e.pc = 5'd9;  e.data = mem[9];  sb.push_back(e);
    e.pc = 5'd10; e.data = mem[10]; sb.push_back(e);
    e.pc = 5'd11; e.data = mem[11]; sb.push_back(e);
    pulse_start("redirect");
    for (int c = 0; c < 100 && !halted; c++) begin
      redirect_valid = 1'b0;
      instr_ready = 1'b1;
      if (ph == 1) begin
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 5'd9) begin
          failures++;
          $display("FAIL redirect_bubble: vld=%b addr=%0d, expected 0 9", instr_valid, imem_addr);
        end
        ph = 2;
      end else if (ph == 0 && instr_valid && instr_pc == 5'd2) begin
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 5'd9;
        ph = 1;
      end
      if (instr_valid && instr_ready) pop_compare("redirect");
      step();
    end
    redirect_valid = 1'b0;
    checks++;
    if (sb.size() != 0 || halted !== 1'b1 || issue_count !== 16'd5 || ph != 2) begin
      failures++;
      $display("FAIL redirect_end: left=%0d halted=%b cnt=%0d phase=%0d, expected 0 1 5 2",
               sb.size(), halted, issue_count, ph);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 + 32'(i);
    sb.delete();
    for (int i = 0; i < 36; i++) begin
      e.pc = 5'(i % 32); e.data = mem[i % 32];
      sb.push_back(e);
    end
    pulse_start("wrap");
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      instr_ready = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL wrap_busy: busy=%b, expected 1", busy);
      end
      if (instr_valid) pop_compare("wrap");
      step();
    end
    checks++;
    if (sb.size() != 0 || issue_count !== 16'd36) begin
      failures++;
      $display("FAIL wrap_end: left=%0d cnt=%0d, expected 0 36", sb.size(), issue_count);
    end
  endtask

  task automatic test_reset_mid();
    bool_wait: begin end
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_halt_prog();
    pulse_start("reset_mid");
    instr_ready = 1'b1;
    for (int c = 0; c < 20 && imem_addr != 5'd6; c++) step();
    checks++;
    if (imem_addr !== 5'd6) begin
      failures++;
      $display("FAIL reset_mid_reach: addr=%0d, expected 6", imem_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 5'd0 || imem_addr !== 5'd0 ||
        issue_count !== 16'd0 || halted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: vld=%b instr=%h ipc=%0d addr=%0d cnt=%0d halted=%b busy=%b, expected all 0",
               instr_valid, instr, instr_pc, imem_addr, issue_count, halted, busy);
    end
    step();
    reset = 1'b0;
    run_program(1'b0, "reset_mid_rerun");
  endtask

  task automatic test_saturate();
    int n = 0;
    int exp_cnt;
    reset2 = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      ready2 = 1'b1;
      exp_cnt = (n > 15) ? 15 : n;
      checks++;
      if (cnt2 !== 4'(exp_cnt)) begin
        failures++;
        $display("FAIL saturate: cnt=%0d, expected %0d after %0d handshakes", cnt2, exp_cnt, n);
      end
      if (valid2 && ready2) n++;
      step();
    end
    checks++;
    if (cnt2 !== 4'hF || n < 20) begin
      failures++;
      $display("FAIL saturate_end: cnt=%0d handshakes=%0d, expected 15 and >=20", cnt2, n);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_restart();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
